mode_counter: RTL

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter.sv | 60 ++++++
 1 files changed

// File: rtl/mode_counter.sv
// mode_counter: prescaled up/down counter with wrap or saturate, load/clear,
// terminal-count pulse and sticky boundary-crossing flag.
module mode_counter #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter int              PRESCALE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] cnt_q, cnt_d, up_val, dn_val;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             step, at_max, at_zero, boundary;
  always_comb begin
    step     = en && !clr && !load && (pre_q == PLAST);
    at_max   = cnt_q == MAX_VAL;
    at_zero  = cnt_q == '0;
    boundary = step && (dir ? at_max : at_zero);
    up_val   = at_max ? (sat ? MAX_VAL : '0) : cnt_q + WIDTH'(1);
    dn_val   = at_zero ? (sat ? '0 : MAX_VAL) : cnt_q - WIDTH'(1);
    cnt_d    = clr  ? RESET_VAL :
               load ? ((load_val > MAX_VAL) ? MAX_VAL : load_val) :
               step ? (dir ? up_val : dn_val) : cnt_q;
    pre_d    = (clr || load) ? '0 :
               en ? ((pre_q == PLAST) ? '0 : pre_q + PW'(1)) : pre_q;
    tc_d     = boundary;
    // a new boundary crossing outranks a simultaneous clear request
    ovf_d    = boundary || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt_q <= RESET_VAL;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
endmodule
